// File: rtl/tsc_cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the direct-mapped data cache.
package tsc_cache_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned NUM_LINES  = 4;
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W      = $clog2(NUM_LINES);
    localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [TAG_W-1:0] t,
                                                    input logic [IDX_W-1:0] i);
        return {t, i, {OFF_W{1'b0}}};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays: one combinational read port, one word-write port, one line-fill port.
module dcache_line_store
    import tsc_cache_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    data_d [NUM_LINES];

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            dirty_d[fill_idx] = 1'b0;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_line;
        end else if (wr_en) begin
            data_d[wr_idx][wr_off*WORD_W +: WORD_W] = wr_data;
            dirty_d[wr_idx] = 1'b1;
        end
    end

    // Only the status bits need reset; tags and data are meaningless while invalid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: miss FSM, stall, hit/miss counters.
module dcache_ctrl
    import tsc_cache_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              d_readM,
    input  logic              d_writeM,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              cache_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [TAG_W-1:0]  line_tag;
    logic              line_valid, line_dirty;
    logic [LINE_W-1:0] line_data;
    logic              req, hit, wr_en, fill_en;

    state_e            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;
    logic [15:0]       hit_count_q, hit_count_d;
    logic [15:0]       miss_count_q, miss_count_d;
    logic              retry_q, retry_d;

    assign req_tag = addr_tag(d_address);
    assign req_idx = addr_idx(d_address);
    assign req_off = addr_off(d_address);

    dcache_line_store u_store (
        .Clk       (Clk),
        .Reset     (Reset),
        .rd_idx    (req_idx),
        .rd_tag    (line_tag),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_line   (line_data),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_off    (req_off),
        .wr_data   (d_wdata),
        .fill_en   (fill_en),
        .fill_idx  (lat_idx_q),
        .fill_tag  (lat_tag_q),
        .fill_line (mem_rdata)
    );

    assign req         = d_readM | d_writeM;
    assign hit         = line_valid && (line_tag == req_tag);
    assign cache_stall = (state_q != IDLE) || (req && !hit);
    assign d_rdata     = hit ? line_data[req_off*WORD_W +: WORD_W] : '0;
    assign wr_en       = (state_q == IDLE) && d_writeM && hit;
    assign fill_en     = (state_q == REFILL) && mem_ack;

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        lat_tag_d     = lat_tag_q;
        lat_idx_d     = lat_idx_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        retry_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_count_d = sat_inc(miss_count_q);
                    lat_tag_d    = req_tag;
                    lat_idx_d    = req_idx;
                    if (line_valid && line_dirty) begin
                        state_d       = WRITEBACK;
                        mem_write_d   = 1'b1;
                        mem_address_d = line_base(line_tag, req_idx);
                        mem_wdata_d   = line_data;
                    end else begin
                        state_d       = REFILL;
                        mem_read_d    = 1'b1;
                        mem_address_d = line_base(req_tag, req_idx);
                    end
                end else if (req && !retry_q) begin
                    // The replayed request right after a refill is the tail of a miss.
                    hit_count_d = sat_inc(hit_count_q);
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_d       = REFILL;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = line_base(lat_tag_q, lat_idx_q);
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                    retry_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            lat_tag_q     <= '0;
            lat_idx_q     <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            retry_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            lat_tag_q     <= lat_tag_d;
            lat_idx_q     <= lat_idx_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            retry_q       <= retry_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic against a memory-view model.
module tb_dcache_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        d_readM, d_writeM;
    logic [15:0] d_address, d_wdata, d_rdata;
    logic        cache_stall, mem_read, mem_write;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;

    dcache_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .d_readM     (d_readM),
        .d_writeM    (d_writeM),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .cache_stall (cache_stall),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] mem_model [256];
    logic [15:0] arch      [256];
    bit          m_valid   [4];
    bit          m_dirty   [4];
    logic [11:0] m_tag     [4];
    int          exp_hits, exp_misses;
    bit          resp_en;
    bit          late_ack;
    int          rsp_wait;
    bit          rsp_prev_late;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line-wide memory with a random 0..3 cycle ack delay.
    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 40503) ^ 16'h5A5A;
        for (int i = 0; i < 4; i++) mem_model[16 + i] = 16'(i + 1);
        mem_ack = 1'b0;
        mem_rdata = '0;
        rsp_wait = 0;
        rsp_prev_late = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            mem_ack = 1'b0;
            if (late_ack && !rsp_prev_late) begin
                mem_ack = 1'b1;
            end else if (resp_en && (mem_read || mem_write)) begin
                if (rsp_wait == 0) begin
                    for (int j = 0; j < 4; j++) begin
                        logic [7:0] a;
                        a = mem_address[7:0] + 8'(j);
                        if (mem_write) mem_model[a] = mem_wdata[j*16 +: 16];
                        else mem_rdata[j*16 +: 16] = mem_model[a];
                    end
                    mem_ack = 1'b1;
                    rsp_wait = $urandom_range(0, 3);
                end else begin
                    rsp_wait--;
                end
            end
            rsp_prev_late = late_ack;
        end
    end

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Called at posedge+1; returns at posedge+1 with the request retired.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input string tag);
        logic [11:0] t;
        logic [1:0]  idx;
        logic [7:0]  b;
        bit          exp_hit;
        int          k;
        t = addr[15:4];
        idx = addr[3:2];
        exp_hit = m_valid[idx] && (m_tag[idx] == t);
        d_readM = rd;
        d_writeM = wr;
        d_address = addr;
        d_wdata = data;
        @(negedge Clk);
        chk({tag, " stall"}, 64'(cache_stall), 64'(!exp_hit));
        if (!exp_hit) begin
            exp_misses = sat(exp_misses + 1);
            @(negedge Clk);
            if (m_valid[idx] && m_dirty[idx]) begin
                b = {m_tag[idx][3:0], idx, 2'b00};
                chk({tag, " wb_req"}, 64'({mem_write, mem_read}), 64'(2'b10));
                chk({tag, " wb_addr"}, 64'(mem_address), 64'({m_tag[idx], idx, 2'b00}));
                chk({tag, " wb_data"}, mem_wdata,
                    {arch[b + 8'd3], arch[b + 8'd2], arch[b + 8'd1], arch[b]});
            end else begin
                chk({tag, " rf_req"}, 64'({mem_write, mem_read}), 64'(2'b01));
                chk({tag, " rf_addr"}, 64'(mem_address), 64'({t, idx, 2'b00}));
            end
            k = 0;
            while (cache_stall && k < 60) begin
                @(negedge Clk);
                k++;
            end
            chk({tag, " settle"}, 64'(cache_stall), 64'(0));
            m_valid[idx] = 1'b1;
            m_tag[idx] = t;
            m_dirty[idx] = 1'b0;
        end else begin
            exp_hits = sat(exp_hits + 1);
        end
        if (rd && !wr) chk({tag, " rdata"}, 64'(d_rdata), 64'(arch[addr[7:0]]));
        if (wr) begin
            arch[addr[7:0]] = data;
            m_dirty[idx] = 1'b1;
        end
        @(posedge Clk);
        #1;
        d_readM = 1'b0;
        d_writeM = 1'b0;
        chk({tag, " hits"}, 64'(hit_count), 64'(exp_hits));
        chk({tag, " misses"}, 64'(miss_count), 64'(exp_misses));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i] = '0;
        end
        for (int i = 0; i < 256; i++) arch[i] = mem_model[i];
        exp_hits = 0;
        exp_misses = 0;
    endtask

    initial begin
        Reset = 1'b1;
        d_readM = 1'b0;
        d_writeM = 1'b0;
        d_address = '0;
        d_wdata = '0;
        resp_en = 1'b1;
        late_ack = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst stall", 64'(cache_stall), 64'(0));
        chk("rst mem_rw", 64'({mem_read, mem_write}), 64'(0));
        chk("rst mem_addr", 64'(mem_address), 64'(0));
        chk("rst mem_wdata", mem_wdata, 64'(0));
        chk("rst rdata", 64'(d_rdata), 64'(0));
        chk("rst counts", 64'({hit_count, miss_count}), 64'(0));
        Reset = 1'b0;
        model_reset();

        do_req(1'b1, 1'b0, 16'h0013, 16'h0, "cold_read");
        chk("cold_read word", 64'(arch[8'h13]), 64'(4));
        do_req(1'b1, 1'b0, 16'h0011, 16'h0, "read_hit");
        do_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, "write_hit");
        do_req(1'b1, 1'b0, 16'h0052, 16'h0, "evict_dirty");
        do_req(1'b1, 1'b1, 16'h0053, 16'h1234, "rd_wr_both");
        do_req(1'b1, 1'b0, 16'h0053, 16'h0, "rd_wr_readback");
        do_req(1'b1, 1'b0, 16'h0012, 16'h0, "wb_readback");

        repeat (300) begin
            logic [15:0] a;
            int op;
            a = 16'($urandom_range(0, 255));
            op = $urandom_range(0, 2);
            do_req(op != 1, op != 0, a, 16'($urandom), "random");
        end

        // Reset while a refill is outstanding, then a stray ack.
        do_req(1'b1, 1'b0, 16'h0011, 16'h0, "pre_rst");
        resp_en = 1'b0;
        d_readM = 1'b1;
        d_address = 16'h00F1;
        @(negedge Clk);
        chk("mid_rst stall", 64'(cache_stall), 64'(1));
        @(negedge Clk);
        chk("mid_rst mem_read", 64'({mem_write, mem_read}), 64'(2'b01));
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        d_readM = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("post_rst mem_rw", 64'({mem_read, mem_write}), 64'(0));
        chk("post_rst stall", 64'(cache_stall), 64'(0));
        chk("post_rst counts", 64'({hit_count, miss_count}), 64'(0));
        late_ack = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        late_ack = 1'b0;
        resp_en = 1'b1;
        chk("late_ack mem_rw", 64'({mem_read, mem_write}), 64'(0));
        chk("late_ack stall", 64'(cache_stall), 64'(0));
        chk("late_ack counts", 64'({hit_count, miss_count}), 64'(0));
        model_reset();
        do_req(1'b1, 1'b0, 16'h0011, 16'h0, "after_rst");

        // Hit-counter saturation.
        do_req(1'b1, 1'b0, 16'h0011, 16'h0, "sat_prime");
        d_readM = 1'b1;
        d_address = 16'h0011;
        repeat (70000) @(posedge Clk);
        #1;
        d_readM = 1'b0;
        exp_hits = sat(exp_hits + 70000);
        chk("sat hits", 64'(hit_count), 64'(exp_hits));
        chk("sat hits ffff", 64'(hit_count), 64'(16'hFFFF));
        chk("sat misses", 64'(miss_count), 64'(exp_misses));
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, "post_sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
